transpose_stream_ctrl: RTL and testbench



---
 rtl/transpose_stream_ctrl.sv | 125 ++++++++++++
 tb/tb_transpose_stream_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/transpose_stream_ctrl.sv
// Streaming M x N transposer: loads a row-major matrix into a register array, then replays it column by column.
// Optional framing check on s_last is enabled by defining TRANSPOSE_LAST_CHECK_EN.
module transpose_stream_ctrl #(
  parameter int M = 5,
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic [RW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [W-1:0]  r_buf [M][N];

  logic w_s_acc;
  logic w_m_acc;
  logic w_in_end;
  logic w_out_end;

  assign w_s_acc   = s_valid && (r_state == LOAD);
  assign w_m_acc   = m_ready && (r_state == DRAIN);
  assign w_in_end  = (r_r == RW'(M - 1)) && (r_c == CW'(N - 1));
  assign w_out_end = (r_i == RW'(M - 1)) && (r_j == CW'(N - 1));

  // State machine and load/drain counters; counters only move on a handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_r     <= '0;
      r_c     <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_s_acc) begin
            if (r_c == CW'(N - 1)) begin
              r_c <= '0;
              if (r_r == RW'(M - 1)) begin
                r_r     <= '0;
                r_state <= DRAIN;
              end else begin
                r_r <= r_r + RW'(1);
              end
            end else begin
              r_c <= r_c + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_m_acc) begin
            if (r_i == RW'(M - 1)) begin
              r_i <= '0;
              if (r_j == CW'(N - 1)) begin
                r_j     <= '0;
                r_state <= LOAD;
              end else begin
                r_j <= r_j + CW'(1);
              end
            end else begin
              r_i <= r_i + RW'(1);
            end
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  // Element storage is written only during LOAD and deliberately survives reset.
  always_ff @(posedge clk) begin
    if (w_s_acc) begin
      r_buf[r_r][r_c] <= s_data;
    end
  end

  assign s_ready = (r_state == LOAD);
  assign m_valid = (r_state == DRAIN);
  assign m_data  = r_buf[r_i][r_j];
  assign m_last  = (r_state == DRAIN) && w_out_end;
  assign busy    = (r_state == DRAIN) || (r_r != '0) || (r_c != '0);

`ifdef TRANSPOSE_LAST_CHECK_EN
  logic r_err;

  // Sticky framing error: s_last must coincide exactly with the counter-defined last element.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_s_acc && (s_last != w_in_end)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // s_last is ignored; folding it in keeps the port consumed while err stays constant low.
  assign err = s_last & 1'b0;
`endif

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Self-checking bench for transpose_stream_ctrl: directed steps with random data, gaps and backpressure
// compared against a transpose computed directly from the loaded matrix.
module tb_transpose_stream_ctrl;

  localparam int M  = 5;
  localparam int N  = 3;
  localparam int MN = M * N;
`ifdef TRANSPOSE_LAST_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       err;

  logic       d_s_valid = 1'b0;
  logic       d_s_ready;
  logic [7:0] d_s_data = 8'd0;
  logic       d_s_last = 1'b0;
  logic       d_m_valid;
  logic       d_m_ready = 1'b0;
  logic [7:0] d_m_data;
  logic       d_m_last;
  logic       d_busy;
  logic       d_err;

  int total = 0;
  int bad = 0;
  int cur[$];

  always #5 clk = ~clk;

  transpose_stream_ctrl #(.M(M), .N(N), .W(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  transpose_stream_ctrl #(.M(1), .N(1), .W(8)) dut1 (
    .clk(clk), .reset(reset),
    .s_valid(d_s_valid), .s_ready(d_s_ready), .s_data(d_s_data), .s_last(d_s_last),
    .m_valid(d_m_valid), .m_ready(d_m_ready), .m_data(d_m_data), .m_last(d_m_last),
    .busy(d_busy), .err(d_err)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
  endtask

  task automatic fill(input bit rnd, input int base);
    cur.delete();
    for (int k = 0; k < MN; k++) cur.push_back(rnd ? int'($urandom_range(0, 255)) : base + k);
  endtask

  // Streams cur[] in; s_last is raised on element indices lp1 and lp2.
  task automatic load(input bit gaps, input int lp1, input int lp2);
    int k = 0;
    int cyc = 0;
    bit rdy;
    while (k < MN && cyc < 500) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = 8'(cur[k]);
      s_last  = (k == lp1) || (k == lp2);
      rdy     = s_ready;
      @(posedge clk); #1;
      cyc++;
      if (s_valid && rdy) k++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("load_count", k, MN);
    check("first_out_valid", m_valid, 1);
    check("first_out_data", m_data, cur[0] & 255);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic drain(input int mode, input int max_out, input bit offer, input int offer_val);
    int exp_q[$];
    int idx = 0;
    int cyc = 0;
    bit hs;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++)
        exp_q.push_back(cur[i * N + j] & 255);
    if (offer) begin
      s_valid = 1'b1;
      s_data  = 8'(offer_val);
    end
    while (idx < max_out && cyc < 500) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
      check("m_valid", m_valid, 1);
      check("m_data", m_data, exp_q[idx]);
      check("m_last", m_last, (idx == MN - 1) ? 1 : 0);
      check("busy_drain", busy, 1);
      if (offer) check("s_ready_blocked", s_ready, 0);
      hs = m_valid && m_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    m_ready = 1'b0;
    check("drain_count", idx, max_out);
    if (max_out == MN) begin
      check("after_last_s_ready", s_ready, 1);
      check("after_last_m_valid", m_valid, 0);
    end
  endtask

  initial begin
    do_reset();

    // Basic transpose of 0..14 with downstream always ready.
    fill(1'b0, 0);
    load(1'b0, MN - 1, -1);
    drain(0, MN, 1'b0, 0);
    check("idle_busy", busy, 0);

    // Random data, random input gaps, 1,0,0,1 backpressure.
    fill(1'b1, 0);
    load(1'b1, MN - 1, -1);
    drain(1, MN, 1'b0, 0);

    // Random data with random backpressure.
    fill(1'b1, 0);
    load(1'b1, MN - 1, -1);
    drain(2, MN, 1'b0, 0);

    // Back-to-back: second matrix 100..114 offered throughout the first drain.
    fill(1'b0, 0);
    load(1'b0, MN - 1, -1);
    drain(0, MN, 1'b1, 100);
    fill(1'b0, 100);
    load(1'b0, MN - 1, -1);
    drain(0, MN, 1'b0, 0);

    // Reset after 7 outputs, then a fresh matrix.
    fill(1'b0, 0);
    load(1'b0, MN - 1, -1);
    drain(0, 7, 1'b0, 0);
    do_reset();
    fill(1'b0, 0);
    load(1'b0, MN - 1, -1);
    drain(0, MN, 1'b0, 0);

    // Framing: early s_last on element 9.
    fill(1'b1, 0);
    load(1'b0, 9, MN - 1);
    check("err_early_last", err, LC);
    drain(0, MN, 1'b0, 0);
    check("err_sticky", err, LC);
    do_reset();

    // Framing: s_last missing on the final element.
    fill(1'b1, 0);
    load(1'b0, -1, -1);
    check("err_missing_last", err, LC);
    drain(0, MN, 1'b0, 0);
    do_reset();

    // Degenerate 1x1 instance.
    d_s_valid = 1'b1;
    d_s_data  = 8'd42;
    d_s_last  = 1'b1;
    @(posedge clk); #1;
    d_s_valid = 1'b0;
    d_s_last  = 1'b0;
    check("d_m_valid", d_m_valid, 1);
    check("d_m_data", d_m_data, 42);
    check("d_m_last", d_m_last, 1);
    check("d_s_ready_blocked", d_s_ready, 0);
    d_m_ready = 1'b1;
    @(posedge clk); #1;
    d_m_ready = 1'b0;
    check("d_back_to_load", d_s_ready, 1);
    check("d_m_valid_off", d_m_valid, 0);
    check("d_busy_off", d_busy, 0);
    check("d_err", d_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
